sync_fifo_lvl: RTL and testbench

//  Single-clock FIFO with occupancy count, programmable almost-full/almost-empty

---
 rtl/sync_fifo_lvl.sv | 155 +++++++++++++++
 tb/tb_sync_fifo_lvl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// selectable read mode (registered read or first-word-fall-through).
// Any DEPTH >= 2 is supported; pointers wrap explicitly, so DEPTH need not
// be a power of two.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   i_wr_en        write request
//   i_wr_data      write data
//   i_rd_en        read request (FWFT: acknowledge/pop of the head word)
//   o_rd_data      read data
//   o_rd_valid     o_rd_data holds a valid word
//   o_full         count == DEPTH
//   o_empty        count == 0
//   o_almost_full  count >= AF_LEVEL
//   o_almost_empty count <= AE_LEVEL
//   o_count        current occupancy, 0..DEPTH
//   o_overflow     1-cycle pulse: write rejected
//   o_underflow    1-cycle pulse: read rejected
module sync_fifo_lvl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit FWFT       = 1'b0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [DATA_WIDTH-1:0]        i_wr_data,
  input  logic                         i_rd_en,
  output logic [DATA_WIDTH-1:0]        o_rd_data,
  output logic                         o_rd_valid,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_almost_full,
  output logic                         o_almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PtrMax = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfLvl  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeLvl  = CW'(AE_LEVEL);

  // Elaboration-time parameter checks
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_lvl: DEPTH must be >= 2");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_lvl: DATA_WIDTH must be >= 1");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("sync_fifo_lvl: AF_LEVEL must be in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL >= DEPTH)) begin : g_bad_ae
    $error("sync_fifo_lvl: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == DepthC);
  assign w_rd_acc = i_rd_en & ~w_empty;
  // A write into a full FIFO is still taken when a read frees a slot this cycle
  assign w_wr_acc = i_wr_en & (~w_full | w_rd_acc);

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == PtrMax) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= (r_rd_ptr == PtrMax) ? '0 : r_rd_ptr + 1'b1;
      end
      r_count     <= w_count_nxt;
      r_overflow  <= i_wr_en & ~w_wr_acc;
      r_underflow <= i_rd_en & w_empty;
    end
  end

  // Storage is not reset; writes during the reset cycle are dropped
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is always presented; valid whenever the FIFO holds data
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_rd_valid = ~w_empty;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) begin
          r_rd_data <= r_mem[r_rd_ptr];
        end
      end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
  end

  // Flags decode the registered count only, so they lag the op by one cycle
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= AfLvl);
  assign o_almost_empty = (r_count <= AeLvl);
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb_sync_fifo_lvl: self-checking bench for sync_fifo_lvl. Three instances:
//   0: DEPTH=16, registered read, AF_LEVEL=12, AE_LEVEL=3
//   1: DEPTH=5,  registered read (non-power-of-two wrap)
//   2: DEPTH=4,  first-word-fall-through
// A queue-style reference model (ordered list of stored words) predicts every
// output each cycle; directed literal checks pin the model at key points.
module tb_sync_fifo_lvl;

  localparam int DEP [3] = '{16, 5, 4};
  localparam int FW  [3] = '{0, 0, 1};
  localparam int AFL [3] = '{12, 3, 2};
  localparam int AEL [3] = '{3, 2, 2};

  logic       clk;
  logic       rst;
  logic       wr_en   [3];
  logic [7:0] wr_data [3];
  logic       rd_en   [3];
  logic [7:0] rdd     [3];
  logic       rdv     [3];
  logic       full_s  [3];
  logic       empty_s [3];
  logic       af_s    [3];
  logic       ae_s    [3];
  logic       ovf_s   [3];
  logic       unf_s   [3];
  logic [4:0] cnt0;
  logic [2:0] cnt1;
  logic [2:0] cnt2;
  logic [31:0] act_cnt [3];

  assign act_cnt[0] = {27'd0, cnt0};
  assign act_cnt[1] = {29'd0, cnt1};
  assign act_cnt[2] = {29'd0, cnt2};

  // Reference model: words in arrival order, index 0 is the oldest
  logic [7:0] mlist [3][64];
  int         msz   [3];
  logic [7:0] ed    [3];
  logic       ev    [3];
  logic       eo    [3];
  logic       eu    [3];

  int  n_cmp;
  int  n_bad;
  bit  chk_on;

  sync_fifo_lvl #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b0), .AF_LEVEL(12), .AE_LEVEL(3)) u_dut0 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en[0]), .i_wr_data(wr_data[0]), .i_rd_en(rd_en[0]),
    .o_rd_data(rdd[0]), .o_rd_valid(rdv[0]), .o_full(full_s[0]), .o_empty(empty_s[0]),
    .o_almost_full(af_s[0]), .o_almost_empty(ae_s[0]), .o_count(cnt0),
    .o_overflow(ovf_s[0]), .o_underflow(unf_s[0])
  );

  sync_fifo_lvl #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1'b0), .AF_LEVEL(3), .AE_LEVEL(2)) u_dut1 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en[1]), .i_wr_data(wr_data[1]), .i_rd_en(rd_en[1]),
    .o_rd_data(rdd[1]), .o_rd_valid(rdv[1]), .o_full(full_s[1]), .o_empty(empty_s[1]),
    .o_almost_full(af_s[1]), .o_almost_empty(ae_s[1]), .o_count(cnt1),
    .o_overflow(ovf_s[1]), .o_underflow(unf_s[1])
  );

  sync_fifo_lvl #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1'b1), .AF_LEVEL(2), .AE_LEVEL(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en[2]), .i_wr_data(wr_data[2]), .i_rd_en(rd_en[2]),
    .o_rd_data(rdd[2]), .o_rd_valid(rdv[2]), .o_full(full_s[2]), .o_empty(empty_s[2]),
    .o_almost_full(af_s[2]), .o_almost_empty(ae_s[2]), .o_count(cnt2),
    .o_overflow(ovf_s[2]), .o_underflow(unf_s[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", nm, k, act, exp);
    end
  endtask

  task automatic model(input int k, input bit we, input logic [7:0] d, input bit re,
                       input bit rs);
    bit emp, ful, racc, wacc;
    if (rs) begin
      msz[k] = 0;
      ed[k]  = 8'h00;
      ev[k]  = 1'b0;
      eo[k]  = 1'b0;
      eu[k]  = 1'b0;
      return;
    end
    emp  = (msz[k] == 0);
    ful  = (msz[k] == DEP[k]);
    racc = re && !emp;
    wacc = we && (!ful || racc);
    if (FW[k] == 0) begin
      ev[k] = racc;
      if (racc) ed[k] = mlist[k][0];
    end
    if (racc) begin
      for (int j = 0; j < 63; j++) mlist[k][j] = mlist[k][j+1];
      msz[k]--;
    end
    if (wacc) begin
      mlist[k][msz[k]] = d;
      msz[k]++;
    end
    eo[k] = we && !wacc;
    eu[k] = re && emp;
  endtask

  // Drive one cycle on instance i (others idle), advance the model at the edge
  task automatic step(input int i, input bit w, input logic [7:0] d, input bit r,
                      input bit rs);
    for (int k = 0; k < 3; k++) begin
      wr_en[k]   = (k == i) && w;
      rd_en[k]   = (k == i) && r;
      wr_data[k] = d;
    end
    rst = rs;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model(k, wr_en[k], wr_data[k], rd_en[k], rs);
    @(negedge clk);
  endtask

  // Compare every output of every instance against the model each cycle
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        automatic int sz = msz[k];
        cmp("count", k, act_cnt[k], sz);
        cmp("empty", k, {31'd0, empty_s[k]}, (sz == 0) ? 1 : 0);
        cmp("full", k, {31'd0, full_s[k]}, (sz == DEP[k]) ? 1 : 0);
        cmp("almost_full", k, {31'd0, af_s[k]}, (sz >= AFL[k]) ? 1 : 0);
        cmp("almost_empty", k, {31'd0, ae_s[k]}, (sz <= AEL[k]) ? 1 : 0);
        cmp("overflow", k, {31'd0, ovf_s[k]}, {31'd0, eo[k]});
        cmp("underflow", k, {31'd0, unf_s[k]}, {31'd0, eu[k]});
        if (FW[k] == 0) begin
          cmp("rd_valid", k, {31'd0, rdv[k]}, {31'd0, ev[k]});
          cmp("rd_data", k, {24'd0, rdd[k]}, {24'd0, ed[k]});
        end else begin
          cmp("rd_valid", k, {31'd0, rdv[k]}, (sz > 0) ? 1 : 0);
          if (sz > 0) cmp("rd_data", k, {24'd0, rdd[k]}, {24'd0, mlist[k][0]});
        end
      end
    end
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    chk_on = 1'b0;
    for (int k = 0; k < 3; k++) msz[k] = 0;

    step(0, 0, 8'h00, 0, 1);
    chk_on = 1'b1;
    cmp("lit_reset_count", 0, act_cnt[0], 0);
    cmp("lit_reset_empty", 0, {31'd0, empty_s[0]}, 1);
    cmp("lit_reset_ae", 0, {31'd0, ae_s[0]}, 1);
    cmp("lit_reset_valid", 0, {31'd0, rdv[0]}, 0);

    // Fill 16, check flag thresholds on the way up
    for (int j = 0; j < 16; j++) begin
      step(0, 1, 8'(j), 0, 0);
      if (j == 2)  cmp("lit_ae_at3", 0, {31'd0, ae_s[0]}, 1);
      if (j == 3)  cmp("lit_ae_at4", 0, {31'd0, ae_s[0]}, 0);
      if (j == 10) cmp("lit_af_at11", 0, {31'd0, af_s[0]}, 0);
      if (j == 11) cmp("lit_af_at12", 0, {31'd0, af_s[0]}, 1);
    end
    cmp("lit_full_count", 0, act_cnt[0], 16);
    cmp("lit_full_flag", 0, {31'd0, full_s[0]}, 1);
    step(0, 1, 8'hFF, 0, 0);
    cmp("lit_overflow", 0, {31'd0, ovf_s[0]}, 1);
    cmp("lit_ovf_count", 0, act_cnt[0], 16);
    step(0, 0, 8'h00, 0, 0);
    cmp("lit_ovf_pulse_end", 0, {31'd0, ovf_s[0]}, 0);
    for (int j = 0; j < 16; j++) begin
      step(0, 0, 8'h00, 1, 0);
      cmp("lit_rd_valid", 0, {31'd0, rdv[0]}, 1);
      cmp("lit_rd_data", 0, {24'd0, rdd[0]}, j);
      if (j == 3)  cmp("lit_af_at12_dn", 0, {31'd0, af_s[0]}, 1);
      if (j == 4)  cmp("lit_af_at11_dn", 0, {31'd0, af_s[0]}, 0);
      if (j == 11) cmp("lit_ae_at4_dn", 0, {31'd0, ae_s[0]}, 0);
      if (j == 12) cmp("lit_ae_at3_dn", 0, {31'd0, ae_s[0]}, 1);
    end
    step(0, 0, 8'h00, 0, 0);
    cmp("lit_drained_valid", 0, {31'd0, rdv[0]}, 0);
    cmp("lit_drained_empty", 0, {31'd0, empty_s[0]}, 1);

    // Simultaneous read/write on full, then on empty
    for (int j = 0; j < 16; j++) step(0, 1, 8'(8'h10 + j), 0, 0);
    step(0, 1, 8'hAA, 1, 0);
    cmp("lit_fullrw_data", 0, {24'd0, rdd[0]}, 32'h10);
    cmp("lit_fullrw_count", 0, act_cnt[0], 16);
    cmp("lit_fullrw_ovf", 0, {31'd0, ovf_s[0]}, 0);
    for (int j = 0; j < 16; j++) step(0, 0, 8'h00, 1, 0);
    cmp("lit_last_is_aa", 0, {24'd0, rdd[0]}, 32'hAA);
    step(0, 1, 8'h77, 1, 0);
    cmp("lit_emptyrw_unf", 0, {31'd0, unf_s[0]}, 1);
    cmp("lit_emptyrw_count", 0, act_cnt[0], 1);
    cmp("lit_emptyrw_valid", 0, {31'd0, rdv[0]}, 0);
    step(0, 0, 8'h00, 1, 0);
    cmp("lit_emptyrw_word", 0, {24'd0, rdd[0]}, 32'h77);

    // Reset mid-operation
    for (int j = 0; j < 9; j++) step(0, 1, 8'(8'h30 + j), 0, 0);
    cmp("lit_pre_rst_count", 0, act_cnt[0], 9);
    step(0, 1, 8'h99, 0, 1);
    cmp("lit_rst_count", 0, act_cnt[0], 0);
    cmp("lit_rst_empty", 0, {31'd0, empty_s[0]}, 1);
    cmp("lit_rst_data", 0, {24'd0, rdd[0]}, 0);
    step(0, 1, 8'h42, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    cmp("lit_post_rst_data", 0, {24'd0, rdd[0]}, 32'h42);
    step(0, 0, 8'h00, 1, 0);
    cmp("lit_post_rst_unf", 0, {31'd0, unf_s[0]}, 1);

    // Non-power-of-two depth across pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 5; j++) step(1, 1, 8'(r * 5 + j + 1), 0, 0);
      cmp("lit_d5_full", 1, {31'd0, full_s[1]}, 1);
      for (int j = 0; j < 5; j++) begin
        step(1, 0, 8'h00, 1, 0);
        cmp("lit_d5_data", 1, {24'd0, rdd[1]}, r * 5 + j + 1);
      end
      cmp("lit_d5_empty", 1, {31'd0, empty_s[1]}, 1);
      cmp("lit_d5_count", 1, act_cnt[1], 0);
    end

    // First-word-fall-through
    step(2, 0, 8'h00, 0, 0);
    cmp("lit_fwft_idle_valid", 2, {31'd0, rdv[2]}, 0);
    step(2, 1, 8'h5A, 0, 0);
    cmp("lit_fwft_valid", 2, {31'd0, rdv[2]}, 1);
    cmp("lit_fwft_data", 2, {24'd0, rdd[2]}, 32'h5A);
    step(2, 0, 8'h00, 1, 0);
    cmp("lit_fwft_pop_valid", 2, {31'd0, rdv[2]}, 0);
    cmp("lit_fwft_pop_empty", 2, {31'd0, empty_s[2]}, 1);
    for (int j = 1; j <= 4; j++) step(2, 1, 8'(j), 0, 0);
    step(2, 1, 8'h05, 1, 0);
    cmp("lit_fwft_rw_head", 2, {24'd0, rdd[2]}, 2);
    cmp("lit_fwft_rw_count", 2, act_cnt[2], 4);
    for (int j = 0; j < 5; j++) step(2, 0, 8'h00, 1, 0);
    cmp("lit_fwft_unf", 2, {31'd0, unf_s[2]}, 1);
    step(2, 0, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
